fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 168 ++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Two-requester write arbiter feeding one downstream FIFO.
// Grants are held for a whole packet, or, when PKT_MODE=0, also cut by a beat limit or by an idle owner.
module fifo_wr_arbiter #(
    parameter int PKT_MODE  = 1,
    parameter int MAX_BURST = 16
) (
    input  logic        clk,
    input  logic        srst_n,

    input  logic        a_valid,
    input  logic        a_last,
    input  logic [7:0]  a_data,
    output logic        a_ready,

    input  logic        b_valid,
    input  logic        b_last,
    input  logic [7:0]  b_data,
    output logic        b_ready,

    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [7:0]  fifo_din,

    output logic [1:0]  grant,
    output logic        busy,
    output logic [15:0] a_count,
    output logic [15:0] b_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SERVE_A = 2'b01,
        SERVE_B = 2'b10
    } state_t;

    localparam logic       BURST_MODE = (PKT_MODE == 0);
    localparam logic [8:0] BURST_LIM  = 9'(MAX_BURST);

    state_t      state_q, state_d;
    logic        last_b_q, last_b_d;   // 1: B was the most recent owner to release
    logic [7:0]  beat_q, beat_d;
    logic [15:0] a_count_q, a_count_d;
    logic [15:0] b_count_q, b_count_d;

    logic        a_xfer, b_xfer;
    logic        own_valid, own_last, own_xfer, other_valid;
    logic        release_now;
    logic [8:0]  beat_inc;
    state_t      own_state, other_state;

    // Handshake: a byte moves exactly when valid and ready are both high in
    // the same cycle; ready depends only on ownership and fifo_full, never on valid.
    assign a_ready    = (state_q == SERVE_A) && !fifo_full;
    assign b_ready    = (state_q == SERVE_B) && !fifo_full;
    assign a_xfer     = a_valid && a_ready;
    assign b_xfer     = b_valid && b_ready;
    assign fifo_wr_en = a_xfer || b_xfer;

    always_comb begin
        fifo_din = 8'h00;
        case (state_q)
            SERVE_A: fifo_din = a_data;
            SERVE_B: fifo_din = b_data;
            default: fifo_din = 8'h00;
        endcase
    end

    assign grant   = state_q;
    assign busy    = (state_q != IDLE);
    assign a_count = a_count_q;
    assign b_count = b_count_q;

    // Owner-relative view so both SERVE states share one release rule.
    always_comb begin
        own_valid   = 1'b0;
        own_last    = 1'b0;
        own_xfer    = 1'b0;
        other_valid = 1'b0;
        own_state   = IDLE;
        other_state = IDLE;
        if (state_q == SERVE_A) begin
            own_valid   = a_valid;
            own_last    = a_last;
            own_xfer    = a_xfer;
            other_valid = b_valid;
            own_state   = SERVE_A;
            other_state = SERVE_B;
        end else if (state_q == SERVE_B) begin
            own_valid   = b_valid;
            own_last    = b_last;
            own_xfer    = b_xfer;
            other_valid = a_valid;
            own_state   = SERVE_B;
            other_state = SERVE_A;
        end
    end

    assign beat_inc = {1'b0, beat_q} + 9'd1;

    always_comb begin
        release_now = 1'b0;
        if (state_q != IDLE && !fifo_full) begin
            release_now = (own_xfer && (own_last || (BURST_MODE && beat_inc == BURST_LIM)))
                       || (BURST_MODE && !own_valid && other_valid);
        end
    end

    always_comb begin
        state_d   = state_q;
        last_b_d  = last_b_q;
        beat_d    = beat_q;
        a_count_d = a_count_q + 16'(a_xfer);
        b_count_d = b_count_q + 16'(b_xfer);

        // A full FIFO freezes arbitration as well as data movement.
        if (!fifo_full) begin
            case (state_q)
                IDLE: begin
                    beat_d = 8'd0;
                    if (a_valid && b_valid) begin
                        state_d = last_b_q ? SERVE_A : SERVE_B;
                    end else if (a_valid) begin
                        state_d = SERVE_A;
                    end else if (b_valid) begin
                        state_d = SERVE_B;
                    end
                end
                SERVE_A, SERVE_B: begin
                    if (own_xfer) begin
                        beat_d = beat_q + 8'd1;
                    end
                    if (release_now) begin
                        last_b_d = (state_q == SERVE_B);
                        beat_d   = 8'd0;
                        if (other_valid) begin
                            state_d = other_state;
                        end else if (own_valid) begin
                            state_d = own_state;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    beat_d  = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state_q   <= IDLE;
            last_b_q  <= 1'b1;
            beat_q    <= 8'd0;
            a_count_q <= 16'd0;
            b_count_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            last_b_q  <= last_b_d;
            beat_q    <= beat_d;
            a_count_q <= a_count_d;
            b_count_q <= b_count_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a packet-mode instance and a burst-mode (MAX_BURST=4) instance,
// each driven by its own random packet sources and checked against an owner/beat reference model.
module tb_fifo_wr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        srst_n;
    logic        a_valid [2], a_last [2], a_ready [2];
    logic        b_valid [2], b_last [2], b_ready [2];
    logic [7:0]  a_data [2], b_data [2], fifo_din [2];
    logic        fifo_full [2], fifo_wr_en [2], busy [2];
    logic [1:0]  grant [2];
    logic [15:0] a_count [2], b_count [2];

    fifo_wr_arbiter #(.PKT_MODE(1), .MAX_BURST(16)) u_pkt (
        .clk(clk), .srst_n(srst_n),
        .a_valid(a_valid[0]), .a_last(a_last[0]), .a_data(a_data[0]), .a_ready(a_ready[0]),
        .b_valid(b_valid[0]), .b_last(b_last[0]), .b_data(b_data[0]), .b_ready(b_ready[0]),
        .fifo_full(fifo_full[0]), .fifo_wr_en(fifo_wr_en[0]), .fifo_din(fifo_din[0]),
        .grant(grant[0]), .busy(busy[0]), .a_count(a_count[0]), .b_count(b_count[0])
    );

    fifo_wr_arbiter #(.PKT_MODE(0), .MAX_BURST(4)) u_burst (
        .clk(clk), .srst_n(srst_n),
        .a_valid(a_valid[1]), .a_last(a_last[1]), .a_data(a_data[1]), .a_ready(a_ready[1]),
        .b_valid(b_valid[1]), .b_last(b_last[1]), .b_data(b_data[1]), .b_ready(b_ready[1]),
        .fifo_full(fifo_full[1]), .fifo_wr_en(fifo_wr_en[1]), .fifo_din(fifo_din[1]),
        .grant(grant[1]), .busy(busy[1]), .a_count(a_count[1]), .b_count(b_count[1])
    );

    int n_cmp = 0;
    int n_err = 0;

    // Sources: index k = dut*2 + requester (0 = A, 1 = B); entries are {last, data}.
    logic [8:0] src_q [4][$];
    // Scoreboard: expected {grant, din} for every write, per instance.
    logic [9:0] exp_q [2][$];

    int gap_pct, full_pct, fill_pct, len_min, len_max;

    // Reference model: owner 0 = none, 1 = A, 2 = B.
    int m_pkt [2] = '{1, 0};
    int m_mb  [2] = '{16, 4};
    int m_owner [2], m_last [2], m_beats [2], m_acnt [2], m_bcnt [2];
    int n_owner [2], n_last [2], n_beats [2], n_acnt [2], n_bcnt [2];
    bit m_xa [2], m_xb [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = 0; m_last[d] = 2; m_beats[d] = 0; m_acnt[d] = 0; m_bcnt[d] = 0;
            n_owner[d] = 0; n_last[d] = 2; n_beats[d] = 0; n_acnt[d] = 0; n_bcnt[d] = 0;
            m_xa[d] = 1'b0; m_xb[d] = 1'b0;
        end
    endtask

    task automatic add_pkt(input int k, input int len);
        for (int i = 0; i < len; i++) begin
            src_q[k].push_back({(i == len - 1), 8'($urandom_range(255))});
        end
    endtask

    task automatic drive_inputs();
        logic [8:0] w;
        logic       v;
        for (int d = 0; d < 2; d++) begin
            fifo_full[d] = (int'($urandom_range(99)) < full_pct);
            for (int r = 0; r < 2; r++) begin
                v = (src_q[d*2+r].size() != 0) && (int'($urandom_range(99)) >= gap_pct);
                w = (src_q[d*2+r].size() != 0) ? src_q[d*2+r][0] : 9'h000;
                if (r == 0) begin
                    a_valid[d] = v; a_last[d] = w[8]; a_data[d] = w[7:0];
                end else begin
                    b_valid[d] = v; b_last[d] = w[8]; b_data[d] = w[7:0];
                end
            end
        end
    endtask

    task automatic drive_idle();
        for (int d = 0; d < 2; d++) begin
            a_valid[d] = 1'b0; a_last[d] = 1'b0; a_data[d] = 8'h00;
            b_valid[d] = 1'b0; b_last[d] = 1'b0; b_data[d] = 8'h00;
            fifo_full[d] = 1'b0;
        end
    endtask

    // Checks this cycle's outputs, queues the expected write, and works out the next owner.
    task automatic predict();
        bit ra, rb, xa, xb, xv, ov, xl, x, rel;
        logic [1:0] eg;
        logic [7:0] ed;
        int own;
        for (int d = 0; d < 2; d++) begin
            own = m_owner[d];
            ra = (own == 1) && !fifo_full[d];
            rb = (own == 2) && !fifo_full[d];
            xa = a_valid[d] && ra;
            xb = b_valid[d] && rb;
            eg = (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00;
            ed = (own == 1) ? a_data[d] : (own == 2) ? b_data[d] : 8'h00;
            chk($sformatf("ctl%0d grant,busy,ar,br,wr", d),
                {grant[d], busy[d], a_ready[d], b_ready[d], fifo_wr_en[d]},
                {eg, own != 0, ra, rb, xa || xb});
            chk($sformatf("din%0d", d), fifo_din[d], ed);
            if (xa || xb) exp_q[d].push_back({eg, ed});
            m_xa[d] = xa;
            m_xb[d] = xb;

            n_owner[d] = own;
            n_last[d]  = m_last[d];
            n_beats[d] = m_beats[d];
            n_acnt[d]  = (m_acnt[d] + int'(xa)) % 65536;
            n_bcnt[d]  = (m_bcnt[d] + int'(xb)) % 65536;
            if (!fifo_full[d]) begin
                if (own == 0) begin
                    n_beats[d] = 0;
                    if (a_valid[d] && b_valid[d]) n_owner[d] = (m_last[d] == 2) ? 1 : 2;
                    else if (a_valid[d])          n_owner[d] = 1;
                    else if (b_valid[d])          n_owner[d] = 2;
                end else begin
                    xv = (own == 1) ? a_valid[d] : b_valid[d];
                    ov = (own == 1) ? b_valid[d] : a_valid[d];
                    xl = (own == 1) ? a_last[d]  : b_last[d];
                    x  = xa || xb;
                    if (x) n_beats[d] = m_beats[d] + 1;
                    rel = (x && (xl || (m_pkt[d] == 0 && n_beats[d] == m_mb[d])))
                       || (m_pkt[d] == 0 && !xv && ov);
                    if (rel) begin
                        n_last[d]  = own;
                        n_beats[d] = 0;
                        n_owner[d] = ov ? (3 - own) : (xv ? own : 0);
                    end
                end
            end
        end
    endtask

    task automatic commit();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = n_owner[d]; m_last[d] = n_last[d]; m_beats[d] = n_beats[d];
            m_acnt[d]  = n_acnt[d];  m_bcnt[d] = n_bcnt[d];
            if (m_xa[d]) void'(src_q[d*2].pop_front());
            if (m_xb[d]) void'(src_q[d*2+1].pop_front());
        end
        for (int k = 0; k < 4; k++) begin
            if (src_q[k].size() == 0 && int'($urandom_range(99)) < fill_pct)
                add_pkt(k, int'($urandom_range(len_max, len_min)));
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic run_cycles(input int n);
        repeat (n) begin
            drive_inputs();
            #1 predict();
            @(negedge clk);
            commit();
        end
    endtask

    task automatic set_knobs(input int gap, input int full, input int fill, input int lmin, input int lmax);
        gap_pct = gap; full_pct = full; fill_pct = fill; len_min = lmin; len_max = lmax;
    endtask

    task automatic check_counts(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s a_count%0d", tag, d), a_count[d], 64'(m_acnt[d]));
            chk($sformatf("%s b_count%0d", tag, d), b_count[d], 64'(m_bcnt[d]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s outputs%0d", tag, d),
                {grant[d], busy[d], a_ready[d], b_ready[d], fifo_wr_en[d], fifo_din[d],
                 a_count[d], b_count[d]}, 64'd0);
        end
    endtask

    // Scoreboard monitor: runs after predict() in each low phase of the clock.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            #2;
            for (int d = 0; d < 2; d++) begin
                if (fifo_wr_en[d] === 1'b1) begin
                    if (exp_q[d].size() == 0) begin
                        chk($sformatf("wr_unexpected%0d", d), 64'(fifo_wr_en[d]), 64'd0);
                    end else begin
                        e = exp_q[d].pop_front();
                        chk($sformatf("wr_data%0d", d), {grant[d], fifo_din[d]}, 64'(e));
                    end
                end else if (exp_q[d].size() != 0) begin
                    chk($sformatf("wr_missing%0d", d), 64'(fifo_wr_en[d]), 64'd1);
                    exp_q[d].delete();
                end
            end
        end
    end

    initial begin
        srst_n = 1'b0;
        drive_idle();
        model_reset();
        set_knobs(0, 0, 0, 1, 1);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        srst_n = 1'b1;

        // Single 3-byte packet from A on the packet-mode instance.
        src_q[0].push_back({1'b0, 8'h11});
        src_q[0].push_back({1'b0, 8'h22});
        src_q[0].push_back({1'b1, 8'h33});
        run_cycles(7);
        chk("single_pkt a_count", a_count[0], 64'd3);
        check_counts("single_pkt");

        // Both requesters with back-to-back 2-byte packets.
        for (int d = 0; d < 2; d++) begin
            add_pkt(d*2, 2);   add_pkt(d*2, 2);
            add_pkt(d*2+1, 2); add_pkt(d*2+1, 2);
        end
        run_cycles(14);
        check_counts("alternate");

        // Random gaps and FIFO backpressure.
        set_knobs(30, 20, 50, 1, 6);
        run_cycles(500);
        check_counts("random");

        // Long packets, always valid: burst-mode instance rotates every 4 beats.
        set_knobs(0, 0, 100, 40, 40);
        run_cycles(200);
        check_counts("burst");

        // Drain, then catch B mid-packet and reset asynchronously.
        set_knobs(0, 0, 0, 1, 1);
        run_cycles(200);
        add_pkt(1, 10);
        add_pkt(3, 10);
        run_cycles(4);
        drive_inputs();
        #1 predict();
        #2 srst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        model_reset();
        for (int k = 0; k < 4; k++) src_q[k].delete();
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        srst_n = 1'b1;

        // Both valid after reset: A must win the first tie.
        for (int d = 0; d < 2; d++) begin
            add_pkt(d*2, 3);
            add_pkt(d*2+1, 3);
        end
        run_cycles(12);
        check_counts("post_reset");

        set_knobs(25, 15, 60, 1, 8);
        run_cycles(400);
        check_counts("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
